reg_scoreboard: RTL and testbench

- Parametrised register scoreboard and hazard unit for the in-order pipeline. It replaces the fixed three-stage rs/rd compare stall with per-register tracking of outstanding writes.
- Each outstanding write carries a latency countdown, so the unit supports variable-latency units (ALU, load, multi-cycle mul/div) and optional bypass-aware issue.
- Sits at decode/issue: decode presents sources and destination, the unit answers issue_ready, and writeback retires destinations.

---
 rtl/reg_scoreboard.sv | 127 ++++++++++++
 tb/tb_reg_scoreboard.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard / hazard unit tracking outstanding writes per register.
// Define SCOREBOARD_FWD_EN for countdown-based, bypass-aware issue.
module reg_scoreboard #(
   parameter int NUM_REGS   = 32,
   parameter int ADDR_WIDTH = $clog2(NUM_REGS),
   parameter int NUM_SRC    = 2,
   parameter int MAX_LAT    = 7,
   parameter int LAT_WIDTH  = $clog2(MAX_LAT + 1),
   parameter int MAX_OUTST  = 3,
   parameter int OUT_WIDTH  = $clog2(MAX_OUTST + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          issue_valid,
   input  logic [NUM_SRC*ADDR_WIDTH-1:0] issue_rs,
   input  logic [NUM_SRC-1:0]            issue_rs_used,
   input  logic [ADDR_WIDTH-1:0]         issue_rd,
   input  logic                          issue_wen,
   input  logic [LAT_WIDTH-1:0]          issue_lat,
   output logic                          issue_ready,
   output logic                          issue_fire,
   output logic [NUM_SRC-1:0]            src_fwd,
   input  logic                          wb_valid,
   input  logic [ADDR_WIDTH-1:0]         wb_rd,
   output logic [NUM_REGS-1:0]           pending_vec,
   output logic [31:0]                   stall_cycles,
   output logic                          err_spurious_wb
);

   localparam logic [LAT_WIDTH-1:0] LAT_CAP = LAT_WIDTH'(MAX_LAT);
   localparam logic [OUT_WIDTH-1:0] OUT_CAP = OUT_WIDTH'(MAX_OUTST);

   logic [OUT_WIDTH-1:0]  outst [NUM_REGS];
   logic [LAT_WIDTH-1:0]  cnt   [NUM_REGS];
   logic [LAT_WIDTH-1:0]  lat_eff;
   logic [ADDR_WIDTH-1:0] src;
   logic [NUM_SRC-1:0]    fwd;
   logic [NUM_REGS-1:0]   inc;
   logic [NUM_REGS-1:0]   dec;
   logic                  raw;
   logic                  waw;
   logic                  spur;

   assign lat_eff = (issue_lat > LAT_CAP) ? LAT_CAP : issue_lat;

   always_comb begin
      raw = 1'b0;
      fwd = '0;
      src = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src = issue_rs[i*ADDR_WIDTH +: ADDR_WIDTH];
         if (issue_rs_used[i] && src != '0 && outst[src] != '0) begin
`ifdef SCOREBOARD_FWD_EN
            if (cnt[src] != '0) raw = 1'b1;
            else                fwd[i] = 1'b1;
`else
            raw = 1'b1;
`endif
         end
      end
   end

   always_comb begin
      waw = 1'b0;
      if (issue_wen && issue_rd != '0) begin
         if (outst[issue_rd] == OUT_CAP) waw = 1'b1;
`ifdef SCOREBOARD_FWD_EN
         if (outst[issue_rd] != '0 && cnt[issue_rd] > lat_eff) waw = 1'b1;
`else
         if (outst[issue_rd] != '0) waw = 1'b1;
`endif
      end
   end

   assign issue_ready = ~raw & ~waw;
   assign issue_fire  = issue_valid & issue_ready;
   assign src_fwd     = fwd;

   // Both updates look at pre-edge counts, so fire+wb on one reg nets zero.
   always_comb begin
      inc = '0;
      dec = '0;
      pending_vec = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         inc[r] = issue_fire && issue_wen
                  && issue_rd == ADDR_WIDTH'(r);
         dec[r] = wb_valid && wb_rd == ADDR_WIDTH'(r)
                  && outst[r] != '0;
         pending_vec[r] = outst[r] != '0;
      end
   end

   assign spur = wb_valid && wb_rd != '0 && outst[wb_rd] == '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            outst[r] <= '0;
            cnt[r]   <= '0;
         end
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (inc[r])
               cnt[r] <= lat_eff;
            else if (cnt[r] != '0)
               cnt[r] <= cnt[r] - 1'b1;
            if (inc[r] && !dec[r])
               outst[r] <= outst[r] + 1'b1;
            else if (!inc[r] && dec[r])
               outst[r] <= outst[r] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles    <= '0;
         err_spurious_wb <= 1'b0;
      end else begin
         if (issue_valid && !issue_ready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
         if (spur)
            err_spurious_wb <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: step tables, expected handshake queue,
// and a small outstanding-count model for pending/err/stall.
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        issue_valid;
   logic [9:0]  issue_rs;
   logic [1:0]  issue_rs_used;
   logic [4:0]  issue_rd;
   logic        issue_wen;
   logic [2:0]  issue_lat;
   logic        issue_ready;
   logic        issue_fire;
   logic [1:0]  src_fwd;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] pending_vec;
   logic [31:0] stall_cycles;
   logic        err_spurious_wb;

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rs(issue_rs),
      .issue_rs_used(issue_rs_used), .issue_rd(issue_rd),
      .issue_wen(issue_wen), .issue_lat(issue_lat),
      .issue_ready(issue_ready), .issue_fire(issue_fire),
      .src_fwd(src_fwd), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .pending_vec(pending_vec), .stall_cycles(stall_cycles),
      .err_spurious_wb(err_spurious_wb)
   );

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [1:0] used;
      logic [4:0] rd;
      logic       wen;
      logic [2:0] lat;
      logic       wbv;
      logic [4:0] wbrd;
      logic       er;
      logic [1:0] ef;
   } step_t;

   typedef struct {
      logic       ready;
      logic       fire;
      logic [1:0] fwd;
   } exp_t;

   exp_t  q[$];
   int    n_checks = 0;
   int    n_fail = 0;
   int    m_out[32];
   logic  m_err = 1'b0;
   int    exp_stall = 0;

   function automatic step_t S(
      input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [1:0] used, input logic [4:0] rd, input logic wen,
      input logic [2:0] lat, input logic wbv, input logic [4:0] wbrd,
      input logic er, input logic [1:0] ef);
      step_t s;
      s.v = v; s.rs1 = rs1; s.rs2 = rs2; s.used = used;
      s.rd = rd; s.wen = wen; s.lat = lat; s.wbv = wbv;
      s.wbrd = wbrd; s.er = er; s.ef = ef;
      return s;
   endfunction

   function automatic logic [31:0] m_pv();
      logic [31:0] pv = '0;
      for (int r = 1; r < 32; r++) pv[r] = (m_out[r] != 0);
      return pv;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid = 0; issue_rs = '0; issue_rs_used = '0;
      issue_rd = '0; issue_wen = 0; issue_lat = '0;
      wb_valid = 0; wb_rd = '0;
   endtask

   task automatic apply(input step_t s);
      exp_t e;
      issue_valid = s.v; issue_rs = {s.rs2, s.rs1};
      issue_rs_used = s.used; issue_rd = s.rd; issue_wen = s.wen;
      issue_lat = s.lat; wb_valid = s.wbv; wb_rd = s.wbrd;
      e.ready = s.er; e.fire = s.v & s.er; e.fwd = s.ef;
      q.push_back(e);
   endtask

   task automatic model(input step_t s);
      if (s.v && !s.er) exp_stall++;
      if (s.wbv && s.wbrd != 0) begin
         if (m_out[s.wbrd] == 0) m_err = 1'b1;
         else m_out[s.wbrd]--;
      end
      if (s.v && s.er && s.wen && s.rd != 0) m_out[s.rd]++;
   endtask

   task automatic model_clear();
      for (int r = 0; r < 32; r++) m_out[r] = 0;
      m_err = 1'b0;
      exp_stall = 0;
   endtask

   task automatic test_reset();
      n_checks++;
      if (pending_vec !== 32'h0) begin
         n_fail++;
         $display("FAIL reset pending_vec: got %h want 0", pending_vec);
      end
      n_checks++;
      if (issue_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset issue_ready: got %b want 1", issue_ready);
      end
      n_checks++;
      if (stall_cycles !== 32'h0) begin
         n_fail++;
         $display("FAIL reset stall_cycles: got %0d want 0", stall_cycles);
      end
      n_checks++;
      if (src_fwd !== 2'b00 || err_spurious_wb !== 1'b0) begin
         n_fail++;
         $display("FAIL reset fwd/err: got %b/%b want 00/0",
                  src_fwd, err_spurious_wb);
      end
   endtask

   task automatic test_raw();
      step_t s[$];
      exp_t  e;
`ifdef SCOREBOARD_FWD_EN
      s.push_back(S(1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 1, 2'b00));
      s.push_back(S(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 1, 2'b01));
      s.push_back(S(0, 0, 0, 2'b00, 0, 0, 0, 1, 5, 1, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 7, 1, 2, 0, 0, 1, 2'b00));
      s.push_back(S(1, 0, 7, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00));
      s.push_back(S(1, 0, 7, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00));
      s.push_back(S(1, 0, 7, 2'b10, 0, 0, 0, 0, 0, 1, 2'b10));
      s.push_back(S(0, 0, 0, 2'b00, 0, 0, 0, 1, 7, 1, 2'b00));
`else
      s.push_back(S(1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 1, 2'b00));
      s.push_back(S(1, 0, 3, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00));
      s.push_back(S(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00));
      s.push_back(S(1, 3, 0, 2'b01, 0, 0, 0, 1, 3, 0, 2'b00));
      s.push_back(S(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 1, 2'b00));
`endif
      foreach (s[k]) begin
         apply(s[k]);
         #3;
         e = q.pop_front();
         n_checks++;
         if ({issue_ready, issue_fire} !== {e.ready, e.fire}) begin
            n_fail++;
            $display("FAIL raw[%0d] ready/fire: got %b%b want %b%b",
                     k, issue_ready, issue_fire, e.ready, e.fire);
         end
         n_checks++;
         if (src_fwd !== e.fwd) begin
            n_fail++;
            $display("FAIL raw[%0d] src_fwd: got %b want %b",
                     k, src_fwd, e.fwd);
         end
         n_checks++;
         if (pending_vec !== m_pv()) begin
            n_fail++;
            $display("FAIL raw[%0d] pending_vec: got %h want %h",
                     k, pending_vec, m_pv());
         end
         n_checks++;
         if (stall_cycles !== 32'(exp_stall)) begin
            n_fail++;
            $display("FAIL raw[%0d] stall_cycles: got %0d want %0d",
                     k, stall_cycles, exp_stall);
         end
         model(s[k]);
         tick();
      end
      idle_inputs();
      #3;
      n_checks++;
      if (stall_cycles !== 32'(exp_stall)) begin
         n_fail++;
         $display("FAIL raw stall_cycles end: got %0d want %0d",
                  stall_cycles, exp_stall);
      end
      tick();
   endtask

   task automatic test_waw();
      step_t s[$];
      exp_t  e;
`ifdef SCOREBOARD_FWD_EN
      for (int i = 0; i < 3; i++)
         s.push_back(S(1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 1, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 0, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 9, 1, 0, 1, 9, 0, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 1, 2'b00));
      s.push_back(S(0, 0, 0, 2'b00, 0, 0, 0, 1, 9, 1, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 9, 1, 0, 1, 9, 1, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 1, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 0, 2'b00));
      for (int i = 0; i < 3; i++)
         s.push_back(S(0, 0, 0, 2'b00, 0, 0, 0, 1, 9, 1, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 10, 1, 3, 0, 0, 1, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 10, 1, 1, 0, 0, 0, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 10, 1, 3, 0, 0, 1, 2'b00));
      s.push_back(S(0, 0, 0, 2'b00, 0, 0, 0, 1, 10, 1, 2'b00));
      s.push_back(S(0, 0, 0, 2'b00, 0, 0, 0, 1, 10, 1, 2'b00));
`else
      s.push_back(S(1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 1, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 0, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 9, 1, 0, 1, 9, 0, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 1, 2'b00));
      s.push_back(S(0, 0, 0, 2'b00, 0, 0, 0, 1, 9, 1, 2'b00));
`endif
      foreach (s[k]) begin
         apply(s[k]);
         #3;
         e = q.pop_front();
         n_checks++;
         if ({issue_ready, issue_fire} !== {e.ready, e.fire}) begin
            n_fail++;
            $display("FAIL waw[%0d] ready/fire: got %b%b want %b%b",
                     k, issue_ready, issue_fire, e.ready, e.fire);
         end
         n_checks++;
         if (pending_vec !== m_pv()) begin
            n_fail++;
            $display("FAIL waw[%0d] pending_vec: got %h want %h",
                     k, pending_vec, m_pv());
         end
         n_checks++;
         if (err_spurious_wb !== m_err) begin
            n_fail++;
            $display("FAIL waw[%0d] err_spurious_wb: got %b want %b",
                     k, err_spurious_wb, m_err);
         end
         model(s[k]);
         tick();
      end
      idle_inputs();
      #3;
      n_checks++;
      if (pending_vec !== 32'h0 || stall_cycles !== 32'(exp_stall)) begin
         n_fail++;
         $display("FAIL waw drained: got pv=%h stall=%0d want 0/%0d",
                  pending_vec, stall_cycles, exp_stall);
      end
      tick();
   endtask

   task automatic test_edge();
      step_t s[$];
      exp_t  e;
      s.push_back(S(1, 0, 0, 2'b00, 0, 1, 4, 0, 0, 1, 2'b00));
      s.push_back(S(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 1, 2'b00));
      s.push_back(S(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00));
      s.push_back(S(0, 0, 0, 2'b00, 0, 0, 0, 1, 12, 1, 2'b00));
      s.push_back(S(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00));
      s.push_back(S(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00));
      foreach (s[k]) begin
         apply(s[k]);
         #3;
         e = q.pop_front();
         n_checks++;
         if ({issue_ready, issue_fire} !== {e.ready, e.fire}) begin
            n_fail++;
            $display("FAIL edge[%0d] ready/fire: got %b%b want %b%b",
                     k, issue_ready, issue_fire, e.ready, e.fire);
         end
         n_checks++;
         if (pending_vec !== m_pv()) begin
            n_fail++;
            $display("FAIL edge[%0d] pending_vec: got %h want %h",
                     k, pending_vec, m_pv());
         end
         n_checks++;
         if (err_spurious_wb !== m_err) begin
            n_fail++;
            $display("FAIL edge[%0d] err_spurious_wb: got %b want %b",
                     k, err_spurious_wb, m_err);
         end
         model(s[k]);
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      step_t s[$];
      exp_t  e;
      s.push_back(S(1, 0, 0, 2'b00, 1, 1, 5, 0, 0, 1, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 2, 1, 5, 0, 0, 1, 2'b00));
      s.push_back(S(1, 0, 0, 2'b00, 4, 1, 5, 0, 0, 1, 2'b00));
      s.push_back(S(1, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00));
      foreach (s[k]) begin
         apply(s[k]);
         #3;
         e = q.pop_front();
         n_checks++;
         if ({issue_ready, issue_fire} !== {e.ready, e.fire}) begin
            n_fail++;
            $display("FAIL arst[%0d] ready/fire: got %b%b want %b%b",
                     k, issue_ready, issue_fire, e.ready, e.fire);
         end
         n_checks++;
         if (pending_vec !== m_pv()) begin
            n_fail++;
            $display("FAIL arst[%0d] pending_vec: got %h want %h",
                     k, pending_vec, m_pv());
         end
         model(s[k]);
         tick();
      end
      n_checks++;
      if (pending_vec !== 32'h16 || stall_cycles !== 32'(exp_stall)) begin
         n_fail++;
         $display("FAIL arst before: got pv=%h stall=%0d want 16/%0d",
                  pending_vec, stall_cycles, exp_stall);
      end
      #1 rst = 1'b0;
      #1;
      model_clear();
      n_checks++;
      if (pending_vec !== 32'h0 || issue_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL arst cleared: got pv=%h ready=%b want 0/1",
                  pending_vec, issue_ready);
      end
      n_checks++;
      if (stall_cycles !== 32'h0 || err_spurious_wb !== 1'b0
          || src_fwd !== 2'b00) begin
         n_fail++;
         $display("FAIL arst counters: got stall=%0d err=%b fwd=%b want 0",
                  stall_cycles, err_spurious_wb, src_fwd);
      end
      idle_inputs();
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      idle_inputs();
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      tick();
      test_reset();
      test_raw();
      test_waw();
      test_edge();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
